fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID register. It owns the program counter and drives the byte address to the combinational instruction ROM. It captures the returned word into a registered IF output (instruction, PC+4, valid) that feeds IF/ID, and handles stalls from the hazard logic and taken-branch redirects from ID. It also keeps saturating fetch and bubble counters for simulation monitoring.

## Interface
Parameters:
- `ADDR_W`, 8 — ROM address width; ROM address is `pc[ADDR_W-1:0]`.
- `CNT_W`, 16 — width of the performance counters.
- `BRANCH_SQUASH`, 1 — 1: the instruction fetched in the redirect cycle is replaced by a NOP; 0: it is kept (delay slot).

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — reset is asynchronous and active-low.
- `stall`  in  1  — hold PC and IF outputs (from hazard unit).
- `branch_taken`  in  1  — redirect request from ID.
- `branch_target`  in  32  — redirect address.
- `rom_data`  in  32  — instruction word from ROM, combinational on `rom_addr`.
- `rom_addr`  out  ADDR_W  — `pc[ADDR_W-1:0]`, combinational from the PC register.
- `pc_out`  out  32  — current PC register.
- `instr_out`  out  32  — registered instruction to IF/ID.
- `pc_plus4_out`  out  32  — registered PC+4 of `instr_out` (link value for BL).
- `valid_out`  out  1  — `instr_out` is a real fetched instruction (0 = bubble).
- `state_out`  out  2  — current FSM state.
- `fetch_count`  out  CNT_W  — valid instructions delivered.
- `bubble_count`  out  CNT_W  — stall or squash cycles.

## Operation
States (shared encoding): RUN=2'b00, STALL=2'b01, REDIRECT=2'b10.

Per rising edge, priority is `branch_taken` > `stall` > normal.

- **Normal**
  - `pc <= pc + 4`; `instr_out <= rom_data`; `pc_plus4_out <= pc + 4`; `valid_out <= 1`.
  - `fetch_count` increments; next state RUN.
- **Stall**
  - `pc`, `instr_out`, `pc_plus4_out` and `valid_out` hold.
  - `bubble_count` increments; next state STALL.
  - Leaving STALL needs no extra cycle: the first edge with `stall=0` performs a normal fetch.
- **Branch**
  - `pc <= {branch_target[31:2], 2'b00}`; low bits are forced to zero, with no error flag.
  - If `BRANCH_SQUASH=1`: `instr_out <= 32'h00000000`, `valid_out <= 0`, `bubble_count` increments.
  - If `BRANCH_SQUASH=0`: behaves as a normal capture of `rom_data`.
  - Next state REDIRECT.
- **REDIRECT**
  - Lasts exactly one cycle, then normal priority resumes.
  - If `branch_taken` is asserted again in REDIRECT, the new redirect is honoured; the back-to-back branch overrides the older one.
- **Branch and stall together:** the branch wins and the stall is ignored for that edge.

Arithmetic and counters:
- PC arithmetic is modulo 2^32: `32'hFFFFFFFC + 4 = 0`.
- The ROM address wraps naturally at 2^ADDR_W bytes.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset (asynchronous, `reset=0`) forces: `pc=0`, `instr_out=0`, `pc_plus4_out=0`, `valid_out=0`, state RUN, both counters 0.
- Reset asserted mid-stall or mid-redirect clears everything on assertion, with no waiting for `clk`.
- The first rising edge after `reset` releases delivers the word at address 0.
- Latency:
  - `rom_addr` follows `pc` combinationally in the same cycle.
  - Instruction at PC appears on `instr_out` one edge later.
  - After a branch edge, the target instruction appears on `instr_out` at the following edge; this is a single-bubble penalty with squash enabled.
- `stall` and `branch_taken` are sampled only at the rising edge and must be stable before it.

## Structure
- Shared package `fetch_pkg`:
  - state encoding constants.
  - `NOP_WORD = 32'h00000000`.
  - `PC_STEP = 4`.
- One sub-module, `pc_next_sel`: combinational next-PC and next-state selection. It takes `pc`, `stall`, `branch_taken` and `branch_target` and outputs `pc_next`, `state_next` and `squash`. The registers and counters stay in `fetch_stage`.

## Test plan
- **Reset then free-run:** ROM holds `E2110000`, `E7D12000`, `1AFFFFFD`, `E2010000` at byte addresses 0/4/8/12; release reset, 4 edges → `instr_out` sequence as given, `pc_plus4_out` = 4/8/12/16, `valid_out=1`, `fetch_count=4`.
- **Stall:** `stall=1` for 3 edges starting with PC=8 → `pc_out` stays 8, `instr_out` holds, `state_out=01`, `bubble_count=3`; drop stall → next edge fetches address 8's successor, PC=12.
- **Taken branch with squash:** PC=12, `branch_taken=1`, `branch_target=32'h00000006` → next edge PC=4, `instr_out=0`, `valid_out=0`, state REDIRECT; following edge `instr_out=E7D12000`, `valid_out=1`.
- **Branch and stall together:** both asserted at PC=8, target 0 → PC=0, stall ignored, `bubble_count` +1 (squash only).
- **Wrap and saturation:** force PC=`FFFFFFFC` via branch, run 1 edge → PC=0, `rom_addr=0`; with `CNT_W=4`, 20 fetches → `fetch_count=4'hF`.
- **Async reset mid-stall:** pull `reset` low between edges → all outputs zero immediately, before any `clk` edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, the
// squash word and the PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_REDIRECT = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Branch targets are word-aligned silently; misaligned low bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, ROM port and the registered IF
// outputs plus monitoring counters.
interface fetch_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) ();

  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       pc_out;
  logic [31:0]       instr_out;
  logic [31:0]       pc_plus4_out;
  logic              valid_out;
  logic [1:0]        state_out;
  logic [CNT_W-1:0]  fetch_count;
  logic [CNT_W-1:0]  bubble_count;

  // Environment side: hazard unit, ID stage and the instruction ROM.
  modport master (
    output stall, branch_taken, branch_target, rom_data,
    input  rom_addr, pc_out, instr_out, pc_plus4_out, valid_out,
           state_out, fetch_count, bubble_count
  );

  // Fetch stage side.
  modport slave (
    input  stall, branch_taken, branch_target, rom_data,
    output rom_addr, pc_out, instr_out, pc_plus4_out, valid_out,
           state_out, fetch_count, bubble_count
  );

endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC / next-state selection for the fetch stage.
// Priority: branch_taken > stall > sequential fetch.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int BRANCH_SQUASH = 1
) (
  input  logic [31:0]  pc,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic [31:0]  pc_next,
  output fetch_state_e state_next,
  output logic         squash
);

  localparam logic SQUASH_EN = (BRANCH_SQUASH != 0);

  always_comb begin
    pc_next    = pc;
    state_next = ST_RUN;
    squash     = 1'b0;
    if (branch_taken) begin
      // A branch in REDIRECT simply overrides the previous one.
      pc_next    = align_word(branch_target);
      state_next = ST_REDIRECT;
      squash     = SQUASH_EN;
    end else if (stall) begin
      state_next = ST_STALL;
    end else begin
      pc_next    = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM addressing, registered IF/ID
// outputs and saturating fetch/bubble counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int CNT_W         = 16,
  parameter int BRANCH_SQUASH = 1
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.slave bus
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             squash;

  pc_next_sel #(
    .BRANCH_SQUASH(BRANCH_SQUASH)
  ) u_pc_next_sel (
    .pc            (pc_q),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .pc_next       (pc_d),
    .state_next    (state_d),
    .squash        (squash)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A stall holds every IF output; a squashed redirect keeps the old
  // pc_plus4 since it carries no meaning alongside a bubble.
  always_comb begin
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (state_d == ST_STALL) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else if (squash) begin
      instr_d      = NOP_WORD;
      valid_d      = 1'b0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      instr_d      = bus.rom_data;
      pc_plus4_d   = pc_q + PC_STEP;
      valid_d      = 1'b1;
      fetch_cnt_d  = sat_inc(fetch_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      pc_q         <= '0;
      instr_q      <= NOP_WORD;
      pc_plus4_q   <= '0;
      valid_q      <= 1'b0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.rom_addr     = pc_q[ADDR_W-1:0];
  assign bus.pc_out       = pc_q;
  assign bus.instr_out    = instr_q;
  assign bus.pc_plus4_out = pc_plus4_q;
  assign bus.valid_out    = valid_q;
  assign bus.state_out    = state_q;
  assign bus.fetch_count  = fetch_cnt_q;
  assign bus.bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: three instances (squash/16-bit, squash/4-bit counters,
// delay-slot/16-bit) share one directed stimulus and are checked against a model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        cmp_en = 1'b0;
  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(8), .CNT_W(16)) ifa ();
  fetch_if #(.ADDR_W(8), .CNT_W(4))  ifb ();
  fetch_if #(.ADDR_W(8), .CNT_W(16)) ifc ();

  assign ifa.stall = stall;  assign ifa.branch_taken = branch_taken;
  assign ifb.stall = stall;  assign ifb.branch_taken = branch_taken;
  assign ifc.stall = stall;  assign ifc.branch_taken = branch_taken;
  assign ifa.branch_target = branch_target;
  assign ifb.branch_target = branch_target;
  assign ifc.branch_target = branch_target;
  assign ifa.rom_data = rom[ifa.rom_addr[7:2]];
  assign ifb.rom_data = rom[ifb.rom_addr[7:2]];
  assign ifc.rom_data = rom[ifc.rom_addr[7:2]];

  fetch_stage #(.ADDR_W(8), .CNT_W(16), .BRANCH_SQUASH(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  fetch_stage #(.ADDR_W(8), .CNT_W(4),  .BRANCH_SQUASH(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  fetch_stage #(.ADDR_W(8), .CNT_W(16), .BRANCH_SQUASH(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // DUT outputs flattened to 32 bits per instance index.
  logic [31:0] d_pc[3], d_instr[3], d_pp4[3], d_ra[3], d_fc[3], d_bc[3], d_valid[3], d_state[3];
  assign d_pc[0] = ifa.pc_out;        assign d_pc[1] = ifb.pc_out;        assign d_pc[2] = ifc.pc_out;
  assign d_instr[0] = ifa.instr_out;  assign d_instr[1] = ifb.instr_out;  assign d_instr[2] = ifc.instr_out;
  assign d_pp4[0] = ifa.pc_plus4_out; assign d_pp4[1] = ifb.pc_plus4_out; assign d_pp4[2] = ifc.pc_plus4_out;
  assign d_ra[0] = {24'b0, ifa.rom_addr};
  assign d_ra[1] = {24'b0, ifb.rom_addr};
  assign d_ra[2] = {24'b0, ifc.rom_addr};
  assign d_fc[0] = {16'b0, ifa.fetch_count};
  assign d_fc[1] = {28'b0, ifb.fetch_count};
  assign d_fc[2] = {16'b0, ifc.fetch_count};
  assign d_bc[0] = {16'b0, ifa.bubble_count};
  assign d_bc[1] = {28'b0, ifb.bubble_count};
  assign d_bc[2] = {16'b0, ifc.bubble_count};
  assign d_valid[0] = {31'b0, ifa.valid_out};
  assign d_valid[1] = {31'b0, ifb.valid_out};
  assign d_valid[2] = {31'b0, ifc.valid_out};
  assign d_state[0] = {30'b0, ifa.state_out};
  assign d_state[1] = {30'b0, ifb.state_out};
  assign d_state[2] = {30'b0, ifc.state_out};

  function automatic logic [31:0] cnt_max(input int k);
    return (k == 1) ? 32'hF : 32'hFFFF;
  endfunction

  function automatic logic squash_en(input int k);
    return (k != 2);
  endfunction

  // Behavioural model: what each edge must do, by priority branch > stall > fetch.
  logic [31:0] m_pc[3], m_instr[3], m_pp4[3], m_fc[3], m_bc[3], m_valid[3], m_state[3];

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        m_pc[k] <= 0; m_instr[k] <= 0; m_pp4[k] <= 0; m_fc[k] <= 0;
        m_bc[k] <= 0; m_valid[k] <= 0; m_state[k] <= 0;
      end else if (branch_taken) begin
        m_pc[k]    <= branch_target & 32'hFFFF_FFFC;
        m_state[k] <= 2;
        if (squash_en(k)) begin
          m_instr[k] <= 0;
          m_valid[k] <= 0;
          m_bc[k]    <= (m_bc[k] < cnt_max(k)) ? m_bc[k] + 1 : m_bc[k];
        end else begin
          m_instr[k] <= rom[m_pc[k][7:2]];
          m_pp4[k]   <= m_pc[k] + 4;
          m_valid[k] <= 1;
          m_fc[k]    <= (m_fc[k] < cnt_max(k)) ? m_fc[k] + 1 : m_fc[k];
        end
      end else if (stall) begin
        m_state[k] <= 1;
        m_bc[k]    <= (m_bc[k] < cnt_max(k)) ? m_bc[k] + 1 : m_bc[k];
      end else begin
        m_pc[k]    <= m_pc[k] + 4;
        m_instr[k] <= rom[m_pc[k][7:2]];
        m_pp4[k]   <= m_pc[k] + 4;
        m_valid[k] <= 1;
        m_state[k] <= 0;
        m_fc[k]    <= (m_fc[k] < cnt_max(k)) ? m_fc[k] + 1 : m_fc[k];
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("pc", k, d_pc[k], m_pc[k]);
        chk("rom_addr", k, d_ra[k], {24'b0, m_pc[k][7:0]});
        chk("instr", k, d_instr[k], m_instr[k]);
        chk("pc_plus4", k, d_pp4[k], m_pp4[k]);
        chk("valid", k, d_valid[k], m_valid[k]);
        chk("state", k, d_state[k], m_state[k]);
        chk("fetch_count", k, d_fc[k], m_fc[k]);
        chk("bubble_count", k, d_bc[k], m_bc[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic set_in(input logic st, input logic bt, input logic [31:0] tgt);
    stall = st; branch_taken = bt; branch_target = tgt;
  endtask

  task automatic chk_zero(input int k);
    chk("rst_pc", k, d_pc[k], 0);       chk("rst_instr", k, d_instr[k], 0);
    chk("rst_pp4", k, d_pp4[k], 0);     chk("rst_valid", k, d_valid[k], 0);
    chk("rst_state", k, d_state[k], 0); chk("rst_fc", k, d_fc[k], 0);
    chk("rst_bc", k, d_bc[k], 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 | i;
    rom[0] = 32'hE211_0000; rom[1] = 32'hE7D1_2000;
    rom[2] = 32'h1AFF_FFFD; rom[3] = 32'hE201_0000;
    set_in(0, 0, 0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk_zero(0);
    cmp_en = 1'b1;
    @(negedge clk) reset = 1'b1;

    // Free-run from reset.
    step(); chk("fr_instr0", 0, d_instr[0], 32'hE211_0000); chk("fr_pp4_0", 0, d_pp4[0], 4);
    step(); chk("fr_instr1", 0, d_instr[0], 32'hE7D1_2000); chk("fr_pp4_1", 0, d_pp4[0], 8);
    step(); chk("fr_instr2", 0, d_instr[0], 32'h1AFF_FFFD); chk("fr_pp4_2", 0, d_pp4[0], 12);
    step(); chk("fr_instr3", 0, d_instr[0], 32'hE201_0000); chk("fr_pp4_3", 0, d_pp4[0], 16);
    chk("fr_valid", 0, d_valid[0], 1); chk("fr_fc", 0, d_fc[0], 4);

    // Stall for three edges at PC=8.
    set_in(0, 1, 32'h8); step(); chk("br8_pc", 0, d_pc[0], 8);
    set_in(1, 0, 0); repeat (3) step();
    chk("st_pc", 0, d_pc[0], 8); chk("st_state", 0, d_state[0], 1); chk("st_bc", 0, d_bc[0], 4);
    set_in(0, 0, 0); step();
    chk("st_rel_pc", 0, d_pc[0], 12); chk("st_rel_instr", 0, d_instr[0], 32'h1AFF_FFFD);

    // Taken branch to misaligned target 6 from PC=12.
    set_in(0, 1, 32'h6); step();
    chk("br_pc", 0, d_pc[0], 4); chk("br_instr", 0, d_instr[0], 0);
    chk("br_valid", 0, d_valid[0], 0); chk("br_state", 0, d_state[0], 2);
    chk("ds_instr", 2, d_instr[2], 32'hE201_0000); chk("ds_valid", 2, d_valid[2], 1);
    set_in(0, 0, 0); step();
    chk("br_tgt_instr", 0, d_instr[0], 32'hE7D1_2000); chk("br_tgt_valid", 0, d_valid[0], 1);

    // Branch and stall together at PC=8.
    set_in(1, 1, 0); step();
    chk("bs_pc", 0, d_pc[0], 0); chk("bs_bc", 0, d_bc[0], 6);
    set_in(0, 0, 0); step(); chk("bs_instr", 0, d_instr[0], 32'hE211_0000);

    // Back-to-back branches: the younger one wins.
    set_in(0, 1, 32'h20); step();
    set_in(0, 1, 32'hC);  step(); chk("b2b_pc", 0, d_pc[0], 32'hC);
    set_in(0, 0, 0); step(); chk("b2b_instr", 0, d_instr[0], 32'hE201_0000);

    // PC wrap at 2^32.
    set_in(0, 1, 32'hFFFF_FFFF); step();
    chk("wr_pc", 0, d_pc[0], 32'hFFFF_FFFC); chk("wr_ra", 0, d_ra[0], 32'hFC);
    set_in(0, 0, 0); step();
    chk("wr_pc0", 0, d_pc[0], 0); chk("wr_ra0", 0, d_ra[0], 0); chk("wr_pp4", 0, d_pp4[0], 0);

    // Counter saturation on the 4-bit instance.
    repeat (20) step();
    chk("sat_fc", 1, d_fc[1], 32'hF); chk("sat_fc16", 0, d_fc[0], 29); chk("sat_bc", 0, d_bc[0], 9);

    // Asynchronous reset in the middle of a stall.
    set_in(1, 0, 0); step(); step();
    chk("pre_rst_state", 0, d_state[0], 1);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k);
    step();
    set_in(0, 0, 0);
    @(negedge clk) reset = 1'b1;
    step(); chk("post_rst_instr", 0, d_instr[0], 32'hE211_0000); chk("post_rst_pc", 0, d_pc[0], 4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
